bus_host_arbiter: RTL

- Round-robin arbiter that shares the single system bus between multiple hosts, for example a core data port and a future DMA/debug host.
- Sits in front of the bus host ports: it takes each host's request and drives the per-host grant that the bus uses to select the active host for address, write-data and read-data muxing.
- Grant is held for the owning host for its whole transaction.
- Optional hold-limit preemption stops one host from starving the others; a lock input suppresses preemption for atomic sequences.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_host_arbiter_rr_picker.sv | 37 +++
 rtl/bus_host_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: device/host index constants and arbiter state encoding.
package bus_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int DEV_ROM_PORT  = 0;
    localparam int DEV_RAM_PORT  = 1;
    localparam int DEV_UART_PORT = 2;
    localparam int DEV_GPIO_PORT = 3;

    localparam int HOST_CORE_PORT = 0;
    localparam int HOST_DMA_PORT  = 1;

    // Width of an index selecting one of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_host_arbiter_rr_picker.sv
// Round-robin picker: first set bit of mask at or after start_i, wrapping modulo Hosts.
module rr_picker
    import bus_pkg::*;
#(
    parameter int Hosts    = 2,
    parameter int IdxWidth = idx_width(Hosts)
) (
    input  logic [Hosts-1:0]    mask_i,
    input  logic [IdxWidth-1:0] start_i,
    output logic                found_o,
    output logic [IdxWidth-1:0] idx_o
);

    logic [2*Hosts-1:0]  dbl;
    logic [Hosts-1:0]    rot;
    logic [IdxWidth-1:0] off;
    logic [IdxWidth:0]   sum;

    always_comb begin
        dbl = {mask_i, mask_i};
        rot = dbl[start_i +: Hosts];
        off = '0;
        for (int k = Hosts - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k[IdxWidth-1:0];
            end
        end
        // Undo the rotation: offset is relative to start_i.
        sum = {1'b0, start_i} + {1'b0, off};
        if (sum >= (IdxWidth + 1)'(Hosts)) begin
            sum = sum - (IdxWidth + 1)'(Hosts);
        end
        idx_o   = sum[IdxWidth-1:0];
        found_o = |mask_i;
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin bus host arbiter with registered one-hot grant, hold-limit
// preemption and per-host lock for atomic sequences.
module bus_host_arbiter
    import bus_pkg::*;
#(
    parameter int Hosts    = 2,
    parameter int MaxHold  = 16,
    parameter int IdxWidth = idx_width(Hosts)
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [Hosts-1:0]    req_in,
    input  logic [Hosts-1:0]    lock_in,
    output logic [Hosts-1:0]    gnt_out,
    output logic                gnt_valid_out,
    output logic [IdxWidth-1:0] gnt_idx_out,
    output logic                preempt_out
);

    localparam int CntW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;
    localparam bit PreemptEn = (MaxHold != 0);
    localparam logic [CntW-1:0] HoldLim = (MaxHold > 0) ? CntW'(MaxHold - 1) : '0;
    localparam logic [CntW-1:0] HoldMax = CntW'(MaxHold);
    localparam logic [IdxWidth-1:0] LastHost = IdxWidth'(Hosts - 1);

    arb_state_t          state_q, state_d;
    logic [Hosts-1:0]    gnt_q, gnt_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [IdxWidth-1:0] last_q, last_d;
    logic [CntW-1:0]     hold_q, hold_d;
    logic                preempt_q, preempt_d;

    logic [Hosts-1:0]    owner_oh;
    logic [Hosts-1:0]    pick_mask;
    logic [IdxWidth-1:0] start_idx;
    logic                pick_found;
    logic [IdxWidth-1:0] pick_idx;

    // In GRANT the owner is always last_q, so masking it leaves only the waiters.
    assign owner_oh  = Hosts'(1) << last_q;
    assign pick_mask = (state_q == ARB_GRANT) ? (req_in & ~owner_oh) : req_in;
    assign start_idx = (last_q == LastHost) ? '0 : last_q + 1'b1;

    rr_picker #(
        .Hosts    (Hosts),
        .IdxWidth (IdxWidth)
    ) u_picker (
        .mask_i  (pick_mask),
        .start_i (start_idx),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    gnt_d   = Hosts'(1) << pick_idx;
                    idx_d   = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!req_in[last_q]) begin
                    hold_d = '0;
                    if (pick_found) begin
                        gnt_d  = Hosts'(1) << pick_idx;
                        idx_d  = pick_idx;
                        last_d = pick_idx;
                    end else begin
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end else if (PreemptEn && (hold_q >= HoldLim) && !lock_in[last_q] && pick_found) begin
                    gnt_d     = Hosts'(1) << pick_idx;
                    idx_d     = pick_idx;
                    last_d    = pick_idx;
                    hold_d    = '0;
                    preempt_d = 1'b1;
                end else if (!pick_found) begin
                    hold_d = '0;
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= LastHost;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_out       = gnt_q;
    assign gnt_valid_out = |gnt_q;
    assign gnt_idx_out   = idx_q;
    assign preempt_out   = preempt_q;

endmodule
